divide: RTL and testbench



---
 rtl/divide_pkg.sv | 22 ++
 rtl/div_abs_neg.sv | 18 +
 rtl/divide.sv | 174 +++++++++++++++++
 tb/tb_divide.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divide_pkg
// Description : Shared widths, FSM encoding and constants for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
package divide_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [DIV_WIDTH-1:0] c_div0_quotient = '1;

endpackage : divide_pkg
`default_nettype wire

// File: rtl/div_abs_neg.sv
`default_nettype none
// ============================================================================
// Module      : div_abs_neg
// Description : Combinational conditional two's-complement negate.
// Revision    : 1.0 - initial release
// ============================================================================
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_result
);

    assign o_result = i_negate ? (~i_value + WIDTH'(1)) : i_value;

endmodule : div_abs_neg
`default_nettype wire

// File: rtl/divide.sv
`default_nettype none
// ============================================================================
// Module      : divide
// Description : Iterative restoring divider, one quotient bit per cycle,
//               signed (truncating) or unsigned, level begin / registered end.
// Revision    : 1.0 - initial release
// ============================================================================
module divide
    import divide_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_begin,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_op1,
    input  logic [WIDTH-1:0] div_op2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_end
);

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [CNT_W-1:0]   r_count;
    logic               r_neg_quot;
    logic               r_neg_rem;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_end;

    logic [WIDTH-1:0]   w_op1_abs;
    logic [WIDTH-1:0]   w_op2_abs;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH:0]     w_partial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic               w_last;
    logic               w_op2_zero;

    // Operand magnitudes taken at the start edge
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_op1 (
        .i_value  (div_op1),
        .i_negate (div_signed & div_op1[WIDTH-1]),
        .o_result (w_op1_abs)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_op2 (
        .i_value  (div_op2),
        .i_negate (div_signed & div_op2[WIDTH-1]),
        .o_result (w_op2_abs)
    );

    // Result sign fixup; quotient bits accumulate in r_dividend as it shifts
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quot (
        .i_value  (r_dividend),
        .i_negate (r_neg_quot),
        .o_result (w_quot_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .i_value  (r_rem),
        .i_negate (r_neg_rem),
        .o_result (w_rem_fix)
    );

    // Partial remainder keeps the full remainder plus one bit so that a
    // divisor with its MSB set never loses the shifted-out carry.
    assign w_partial  = {r_rem, r_dividend[WIDTH-1]};
    assign w_diff     = w_partial - {1'b0, r_divisor};
    assign w_ge       = (w_partial >= {1'b0, r_divisor});
    assign w_last     = (r_count == CNT_W'(WIDTH - 1));
    assign w_op2_zero = (div_op2 == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (div_begin) begin
                    w_state_next = w_op2_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (!div_begin) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = div_begin ? DONE : IDLE;
            end
            DONE: begin
                if (!div_begin) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_neg_quot  <= 1'b0;
            r_neg_rem   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_end   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_begin) begin
                        r_dividend <= w_op1_abs;
                        r_divisor  <= w_op2_abs;
                        r_rem      <= '0;
                        r_count    <= '0;
                        r_neg_quot <= div_signed & (div_op1[WIDTH-1] ^ div_op2[WIDTH-1]);
                        r_neg_rem  <= div_signed & div_op1[WIDTH-1];
                        if (w_op2_zero) begin
                            r_quotient  <= WIDTH'(c_div0_quotient);
                            r_remainder <= div_op1;
                            r_div_end   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (div_begin) begin
                        r_rem      <= w_ge ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
                        r_dividend <= {r_dividend[WIDTH-2:0], w_ge};
                        r_count    <= r_count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (div_begin) begin
                        r_quotient  <= w_quot_fix;
                        r_remainder <= w_rem_fix;
                        r_div_end   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!div_begin) begin
                        r_div_end <= 1'b0;
                    end
                end
                default: r_div_end <= 1'b0;
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_end   = r_div_end;

endmodule : divide
`default_nettype wire

// File: tb/tb_divide.sv
`default_nettype none
// ============================================================================
// Module      : tb_divide
// Description : Self-checking bench for divide against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divide;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_begin;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_end;

    int checks = 0;
    int errors = 0;

    divide dut (
        .clk        (clk),
        .reset      (reset),
        .div_begin  (div_begin),
        .div_signed (div_signed),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_end    (div_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Truncating division with remainder following the dividend's sign
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint la, lb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'(a);
                lb = longint'(b);
            end
            q = 32'(la / lb);
            r = 32'(la % lb);
        end
    endfunction

    // div_begin is already high; the next rising edge is the start edge
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [31:0] eq, input logic [31:0] er);
        int lat = 0;
        bit seen = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge clk); #1;
            div_op1    = $urandom;
            div_op2    = $urandom;
            div_signed = 1'($urandom);
            if (div_end === 1'b1) begin
                seen = 1;
                lat  = i;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        @(posedge clk); #1;
        check({tag, " end hold"}, {31'd0, div_end}, 32'd1);
        @(negedge clk);
        div_begin = 1'b0;
        @(posedge clk); #1;
        check({tag, " end drop"}, {31'd0, div_end}, 32'd0);
        check({tag, " quotient keep"}, quotient, eq);
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, output logic [31:0] eq, output logic [31:0] er);
        model(a, b, s, eq, er);
        @(negedge clk);
        div_op1    = a;
        div_op2    = b;
        div_signed = s;
        div_begin  = 1'b1;
        wait_done(tag, (b == 32'd0) ? 1 : 34, eq, er);
    endtask

    initial begin
        logic [31:0] eq, er, a, b;
        logic        s;

        reset      = 1'b1;
        div_begin  = 1'b0;
        div_signed = 1'b0;
        div_op1    = '0;
        div_op2    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset end", {31'd0, div_end}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div("u 9/5", 32'h9, 32'h5, 1'b0, eq, er);
        run_div("s -7/2", 32'hFFFF_FFF9, 32'h2, 1'b1, eq, er);
        run_div("u -7/2", 32'hFFFF_FFF9, 32'h2, 1'b0, eq, er);
        run_div("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, eq, er);
        run_div("div0", 32'h1234, 32'h0, 1'b0, eq, er);
        run_div("u big divisor", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, eq, er);

        // Abort part way through; outputs must keep the previous result
        @(negedge clk);
        div_op1    = 32'h0BAD_F00D;
        div_op2    = 32'h13;
        div_signed = 1'b0;
        div_begin  = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        div_begin = 1'b0;
        @(posedge clk); #1;
        check("abort end", {31'd0, div_end}, 32'd0);
        check("abort quotient keep", quotient, eq);
        check("abort remainder keep", remainder, er);
        run_div("after abort", 32'h64, 32'h7, 1'b0, eq, er);

        // Reset in the middle of an operation, then restart with begin held
        @(negedge clk);
        div_op1    = 32'hDEAD_BEEF;
        div_op2    = 32'h7;
        div_signed = 1'b1;
        div_begin  = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset quotient", quotient, 32'd0);
        check("midreset remainder", remainder, 32'd0);
        check("midreset end", {31'd0, div_end}, 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        div_op1    = 32'h1234_5678;
        div_op2    = 32'h1234;
        div_signed = 1'b0;
        model(32'h1234_5678, 32'h1234, 1'b0, eq, er);
        wait_done("after reset", 34, eq, er);

        for (int i = 0; i < 14; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (i == 6) b = 32'd0;
            s = 1'($urandom);
            run_div($sformatf("rand%0d", i), a, b, s, eq, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_divide
`default_nettype wire
